// File: rtl/regfile_pkg.sv
// Shared types and constants for the RISC-V integer register file.
// No ports. Optional feature macro used by users of this package:
// REGFILE_WRITE_BYPASS_EN (same-edge write forwarding into the read ports).
package regfile_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;
   typedef reg_data_t [NUM_REGS-1:0] reg_array_t;

   localparam reg_addr_t ZERO_REG = ADDR_W'(0);

   // True when a write strobe actually updates architectural state
   function automatic logic write_hits(input logic en, input reg_addr_t addr);
      return en && (addr != ZERO_REG);
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the register file.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   regs_i           - full register array contents
//   rd_addr_i        - read address
//   wr_en_i/addr_i/data_i - same-edge write, used only for forwarding
//   rd_data_o        - registered read data (1-cycle latency)
// Macro REGFILE_WRITE_BYPASS_EN: forward a same-edge write to this port.
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  reg_array_t regs_i,
   input  reg_addr_t  rd_addr_i,
   input  logic       wr_en_i,
   input  reg_addr_t  wr_addr_i,
   input  reg_data_t  wr_data_i,
   output reg_data_t  rd_data_o
);

   reg_data_t rd_d;
   reg_data_t rd_q;

`ifdef REGFILE_WRITE_BYPASS_EN
   // Write-before-read: a matching live write wins over the stored value
   always_comb begin
      rd_d = regs_i[rd_addr_i];
      if (write_hits(wr_en_i, wr_addr_i) && (wr_addr_i == rd_addr_i)) begin
         rd_d = wr_data_i;
      end
   end
`else
   // Read-before-write: the stored value is sampled ahead of the write
   always_comb begin
      rd_d = regs_i[rd_addr_i];
   end

   logic unused_bypass_c;
   assign unused_bypass_c = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

   // Output flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

   assign rd_data_o = rd_q;

endmodule

// File: rtl/register_file.sv
// RISC-V integer register file: 32 x 32-bit, x0 hardwired to zero,
// two registered read ports and one write port.
// Ports:
//   clk                - rising-edge clock
//   reset              - asynchronous active-high reset (clears all state)
//   write_en, dst_addr, dst_data - write port
//   src_addr1/src_data1 - read port 1 (1-cycle latency)
//   src_addr2/src_data2 - read port 2 (1-cycle latency)
// Macro REGFILE_WRITE_BYPASS_EN: same-edge writes forward to read ports.
module register_file
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      write_en,
   input  reg_addr_t dst_addr,
   input  reg_data_t dst_data,
   input  reg_addr_t src_addr1,
   input  reg_addr_t src_addr2,
   output reg_data_t src_data1,
   output reg_data_t src_data2
);

   reg_array_t regs_d;
   reg_array_t regs_q;

   // Write logic; writes to x0 are dropped so it stays zero
   always_comb begin
      regs_d = regs_q;
      if (write_hits(write_en, dst_addr)) begin
         regs_d[dst_addr] = dst_data;
      end
   end

   // Storage array
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   regfile_read_port u_rd1 (
      .clk       (clk),
      .rst       (reset),
      .regs_i    (regs_q),
      .rd_addr_i (src_addr1),
      .wr_en_i   (write_en),
      .wr_addr_i (dst_addr),
      .wr_data_i (dst_data),
      .rd_data_o (src_data1)
   );

   regfile_read_port u_rd2 (
      .clk       (clk),
      .rst       (reset),
      .regs_i    (regs_q),
      .rd_addr_i (src_addr2),
      .wr_en_i   (write_en),
      .wr_addr_i (dst_addr),
      .wr_data_i (dst_data),
      .rd_data_o (src_data2)
   );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_register_file;
   import regfile_pkg::*;

   logic      clk = 1'b0;
   logic      reset;
   logic      write_en;
   reg_addr_t dst_addr;
   reg_data_t dst_data;
   reg_addr_t src_addr1;
   reg_addr_t src_addr2;
   reg_data_t src_data1;
   reg_data_t src_data2;

   int vecs = 0;
   int errs = 0;

   // Reference model: architectural register contents and expected outputs
   logic [31:0] model [32];
   logic [31:0] exp1;
   logic [31:0] exp2;

   register_file dut (
      .clk       (clk),
      .reset     (reset),
      .write_en  (write_en),
      .dst_addr  (dst_addr),
      .dst_data  (dst_data),
      .src_addr1 (src_addr1),
      .src_addr2 (src_addr2),
      .src_data1 (src_data1),
      .src_data2 (src_data2)
   );

   always #10 clk = ~clk;

   // Advance one rising edge, updating the model, then settle 1ns past it
   task automatic cycle();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         exp1 = 32'h0;
         exp2 = 32'h0;
      end else begin
         exp1 = model[src_addr1];
         exp2 = model[src_addr2];
`ifdef REGFILE_WRITE_BYPASS_EN
         if (write_en && dst_addr != 0 && dst_addr == src_addr1) exp1 = dst_data;
         if (write_en && dst_addr != 0 && dst_addr == src_addr2) exp2 = dst_data;
`endif
         if (write_en && dst_addr != 0) model[dst_addr] = dst_data;
      end
      #1;
   endtask

   task automatic drive(input logic we, input int da, input logic [31:0] dd,
                        input int a1, input int a2);
      write_en  = we;
      dst_addr  = ADDR_W'(da);
      dst_data  = dd;
      src_addr1 = ADDR_W'(a1);
      src_addr2 = ADDR_W'(a2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 5, 32'hDEAD_BEEF, 5, 0);
      #2;
      vecs++;
      if (src_data1 !== 32'h0 || src_data2 !== 32'h0) begin
         $display("FAIL reset_async: got %h/%h want 0/0", src_data1, src_data2);
         errs++;
      end
      cycle();
      cycle();
      reset = 1'b0;
      drive(1'b0, 0, 32'h0, 0, 1);
      cycle();
      vecs++;
      if (src_data1 !== 32'h0 || src_data2 !== 32'h0) begin
         $display("FAIL reset_read: got %h/%h want 0/0", src_data1, src_data2);
         errs++;
      end
      drive(1'b0, 0, 32'h0, 5, 5);
      cycle();
      vecs++;
      if (src_data1 !== 32'h0 || src_data2 !== 32'h0) begin
         $display("FAIL reset_write_ignored: got %h/%h want 0/0", src_data1, src_data2);
         errs++;
      end
   endtask

   task automatic test_write_gating();
      drive(1'b0, 1, 32'hFFFF_FFFF, 0, 1);
      cycle();
      drive(1'b1, 0, 32'hFFFF_FFFF, 0, 1);
      cycle();
      drive(1'b0, 0, 32'h0, 0, 1);
      cycle();
      vecs++;
      if (src_data1 !== 32'h0 || src_data2 !== 32'h0) begin
         $display("FAIL write_gating: got %h/%h want 0/0", src_data1, src_data2);
         errs++;
      end
   endtask

   task automatic test_basic_rw();
      drive(1'b1, 1, 32'h1, 0, 0);
      cycle();
      drive(1'b1, 2, 32'h2, 0, 0);
      cycle();
      drive(1'b0, 0, 32'h0, 1, 2);
      cycle();
      vecs++;
      if (src_data1 !== 32'h1 || src_data2 !== 32'h2) begin
         $display("FAIL basic_rw: got %h/%h want 1/2", src_data1, src_data2);
         errs++;
      end
      drive(1'b0, 0, 32'h0, 2, 2);
      cycle();
      vecs++;
      if (src_data1 !== 32'h2 || src_data2 !== 32'h2) begin
         $display("FAIL same_addr_both_ports: got %h/%h want 2/2", src_data1, src_data2);
         errs++;
      end
   endtask

   task automatic test_same_edge();
      logic [31:0] want1;
`ifdef REGFILE_WRITE_BYPASS_EN
      want1 = 32'h3;
`else
      want1 = 32'h1;
`endif
      drive(1'b1, 1, 32'h3, 1, 2);
      cycle();
      vecs++;
      if (src_data1 !== want1 || src_data2 !== 32'h2) begin
         $display("FAIL same_edge_rw: got %h/%h want %h/2", src_data1, src_data2, want1);
         errs++;
      end
      drive(1'b0, 0, 32'h0, 1, 2);
      cycle();
      vecs++;
      if (src_data1 !== 32'h3 || src_data2 !== 32'h2) begin
         $display("FAIL same_edge_next: got %h/%h want 3/2", src_data1, src_data2);
         errs++;
      end
      drive(1'b1, 0, 32'h5, 0, 0);
      cycle();
      vecs++;
      if (src_data1 !== 32'h0 || src_data2 !== 32'h0) begin
         $display("FAIL r0_no_forward: got %h/%h want 0/0", src_data1, src_data2);
         errs++;
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 0, 32'h0, 1, 2);
      reset = 1'b1;
      #10;
      vecs++;
      if (src_data1 !== 32'h0 || src_data2 !== 32'h0) begin
         $display("FAIL async_reset_outputs: got %h/%h want 0/0", src_data1, src_data2);
         errs++;
      end
      reset = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      cycle();
      vecs++;
      if (src_data1 !== 32'h0 || src_data2 !== 32'h0) begin
         $display("FAIL async_reset_read: got %h/%h want 0/0", src_data1, src_data2);
         errs++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 2) != 0),
               (($urandom & 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31)),
               $urandom,
               int'($urandom_range(0, 31)),
               (($urandom & 7) == 0) ? int'(src_addr1) : int'($urandom_range(0, 31)));
         if ((n % 4) == 0) src_addr2 = dst_addr;
         cycle();
         vecs++;
         if (src_data1 !== exp1 || src_data2 !== exp2) begin
            $display("FAIL random[%0d]: got %h/%h want %h/%h",
                     n, src_data1, src_data2, exp1, exp2);
            errs++;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      exp1 = 32'h0;
      exp2 = 32'h0;
      test_reset();
      test_write_gating();
      test_basic_rw();
      test_same_edge();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
